link_tx_sequencer: RTL and testbench

Transmit-side link sequencer feeding the 8b10b encoder stage. Each cycle it selects one byte-wide symbol and a control flag (data or K-code) for the encoder: comma alignment bursts after enable, idle fill, and periodic clock-compensation skips. It also wraps upstream byte frames in start-of-frame and end-of-frame K-codes, and pads or aborts frames when the upstream source stalls or the link drops. Running disparity stays in the encoder; this block only schedules symbols.

---
 rtl/link_tx_sequencer.sv | 155 +++++++++++++++
 tb/tb_link_tx_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_sequencer.sv
// Transmit link sequencer: schedules comma/align, idle, skip and framed
// data symbols for the downstream 8b10b encoder stage.
module link_tx_sequencer #(
   parameter int ALIGN_COUNT   = 16,
   parameter int SKIP_INTERVAL = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       link_en,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] sym_out,
   output logic       sym_is_k,
   output logic       sym_valid,
   output logic       aligned,
   output logic       frame_err
);

   localparam int AW = $clog2(ALIGN_COUNT + 1);
   localparam int SW = $clog2(SKIP_INTERVAL);
   localparam logic [AW-1:0] A_LAST = AW'(ALIGN_COUNT - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SKIP_INTERVAL - 1);

   localparam logic [7:0] K_COMMA = 8'hBC;
   localparam logic [7:0] K_SKIP  = 8'h1C;
   localparam logic [7:0] K_SOF   = 8'hFB;
   localparam logic [7:0] K_EOF   = 8'hFD;
   localparam logic [7:0] K_PAD   = 8'hF7;
   localparam logic [7:0] K_ABORT = 8'hFE;

   typedef enum logic [2:0] {
      S_DOWN,
      S_ALIGN,
      S_IDLE,
      S_DATA,
      S_EOF
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] acnt, acnt_n;
   logic [SW-1:0] scnt, scnt_n;
   logic          skip_pend, skip_n;
   logic [7:0]    sym_n;
   logic          k_n, valid_n, aligned_n, err_n, count;

   assign s_ready = (state == S_DATA) && link_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_DOWN;
         acnt      <= '0;
         scnt      <= '0;
         skip_pend <= 1'b0;
         sym_out   <= K_COMMA;
         sym_is_k  <= 1'b1;
         sym_valid <= 1'b0;
         aligned   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         acnt      <= acnt_n;
         scnt      <= scnt_n;
         skip_pend <= skip_n;
         sym_out   <= sym_n;
         sym_is_k  <= k_n;
         sym_valid <= valid_n;
         aligned   <= aligned_n;
         frame_err <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      acnt_n    = acnt;
      scnt_n    = scnt;
      skip_n    = skip_pend;
      sym_n     = K_COMMA;
      k_n       = 1'b1;
      valid_n   = 1'b0;
      aligned_n = aligned;
      err_n     = 1'b0;
      count     = 1'b0;
      if (!link_en) begin
         state_n   = S_DOWN;
         acnt_n    = '0;
         scnt_n    = '0;
         skip_n    = 1'b0;
         aligned_n = 1'b0;
         // Dropping the link mid-frame must tell the far end the frame is dead
         if (state == S_DATA || state == S_EOF) begin
            sym_n   = K_ABORT;
            valid_n = 1'b1;
            err_n   = 1'b1;
         end
      end else begin
         unique case (state)
            S_DOWN: begin
               state_n = S_ALIGN;
               acnt_n  = '0;
            end
            S_ALIGN: begin
               valid_n = 1'b1;
               if (acnt == A_LAST) begin
                  state_n   = S_IDLE;
                  aligned_n = 1'b1;
                  acnt_n    = '0;
               end else begin
                  acnt_n = acnt + 1'b1;
               end
            end
            S_IDLE: begin
               valid_n = 1'b1;
               count   = 1'b1;
               if (skip_pend) begin
                  sym_n  = K_SKIP;
                  skip_n = 1'b0;
               end else if (s_valid) begin
                  sym_n   = K_SOF;
                  state_n = S_DATA;
               end
            end
            S_DATA: begin
               valid_n = 1'b1;
               count   = 1'b1;
               if (s_valid) begin
                  sym_n = s_data;
                  k_n   = 1'b0;
                  if (s_last) state_n = S_EOF;
               end else begin
                  sym_n = K_PAD;
               end
            end
            S_EOF: begin
               valid_n = 1'b1;
               count   = 1'b1;
               sym_n   = K_EOF;
               state_n = S_IDLE;
            end
            default: state_n = S_DOWN;
         endcase
         // A wrap inside a frame stays pending until the next idle slot
         if (count) begin
            if (scnt == S_LAST) begin
               scnt_n = '0;
               skip_n = 1'b1;
            end else begin
               scnt_n = scnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_link_tx_sequencer.sv
// Bench for link_tx_sequencer: directed scenarios plus random traffic,
// checked against a symbol-count reference model.
module tb_link_tx_sequencer;

   localparam int AC = 4;
   localparam int SI = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       link_en = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [7:0] sym_out;
   logic       sym_is_k;
   logic       sym_valid;
   logic       aligned;
   logic       frame_err;

   link_tx_sequencer #(.ALIGN_COUNT(AC), .SKIP_INTERVAL(SI)) dut (
      .clk(clk), .rst_n(rst_n), .link_en(link_en),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .sym_out(sym_out), .sym_is_k(sym_is_k),
      .sym_valid(sym_valid), .aligned(aligned), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   // reference model: link phase plus count of valid symbols since alignment
   bit   m_up, m_in_frame, m_eof_next, m_skip_due;
   int   m_align_left, m_sent;
   logic [7:0] e_sym;
   logic e_k, e_valid, e_err;
   logic e_aligned = 1'b0;

   bit   acc;
   bit   rdy_en = 0;
   logic [8:0] log_q[$];
   logic [7:0] fq[$];

   task automatic chk(input string tag, input logic [8:0] got,
                      input logic [8:0] exp);
      checks++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic go_down();
      m_up = 0; m_align_left = 0; m_in_frame = 0;
      m_eof_next = 0; m_sent = 0; m_skip_due = 0;
      e_aligned = 1'b0;
   endtask

   task automatic model_edge();
      e_err = 1'b0; e_valid = 1'b0; e_sym = 8'hBC; e_k = 1'b1;
      if (!rst_n) go_down();
      else if (!link_en) begin
         if (m_in_frame || m_eof_next) begin
            e_sym = 8'hFE; e_valid = 1'b1; e_err = 1'b1;
         end
         go_down();
      end else if (!m_up) begin
         m_up = 1; m_align_left = AC;
      end else if (m_align_left > 0) begin
         e_valid = 1'b1;
         m_align_left--;
         if (m_align_left == 0) e_aligned = 1'b1;
      end else begin
         e_valid = 1'b1;
         if (m_eof_next) begin
            e_sym = 8'hFD; m_eof_next = 0;
         end else if (m_in_frame) begin
            if (s_valid) begin
               e_sym = s_data; e_k = 1'b0;
               if (s_last) begin m_in_frame = 0; m_eof_next = 1; end
            end else e_sym = 8'hF7;
         end else if (m_skip_due) begin
            e_sym = 8'h1C; m_skip_due = 0;
         end else if (s_valid) begin
            e_sym = 8'hFB; m_in_frame = 1;
         end
         m_sent++;
         if (m_sent % SI == 0) m_skip_due = 1;
      end
   endtask

   task automatic step();
      #2;
      acc = s_valid && s_ready;
      if (rdy_en) chk("s_ready", 9'(s_ready), 9'(m_in_frame && link_en));
      @(posedge clk);
      model_edge();
      #1;
      chk("sym_valid", 9'(sym_valid), 9'(e_valid));
      chk("sym_is_k", 9'(sym_is_k), 9'(e_k));
      chk("sym_out", 9'(sym_out), 9'(e_sym));
      chk("aligned", 9'(aligned), 9'(e_aligned));
      chk("frame_err", 9'(frame_err), 9'(e_err));
      if (sym_valid) log_q.push_back({sym_is_k, sym_out});
      rdy_en = 1;
   endtask

   task automatic wait_skip();
      int n = 0;
      s_valid = 1'b0;
      while (!m_skip_due && n < 20) begin step(); n++; end
      chk("skip_wait", 9'(m_skip_due), 9'd1);
   endtask

   task automatic send(input logic [7:0] b[$], input int stall_idx,
                       input int ncyc, output int nacc);
      int idx = 0;
      int hold = 0;
      nacc = 0;
      log_q.delete();
      for (int c = 0; c < ncyc; c++) begin
         s_valid = (idx < b.size()) && (hold == 0);
         s_data  = (idx < b.size()) ? b[idx] : 8'h00;
         s_last  = (idx == b.size() - 1);
         step();
         if (acc) begin
            nacc++; idx++;
            if (idx == stall_idx) hold = 2;
         end else if (hold > 0) hold--;
      end
      s_valid = 1'b0;
   endtask

   task automatic chk_log(input string tag, input logic [8:0] exp[$]);
      for (int i = 0; i < exp.size(); i++)
         chk(tag, (i < log_q.size()) ? log_q[i] : 9'h0, exp[i]);
   endtask

   task automatic src_update();
      if (acc && fq.size() > 0) fq.delete(0);
      if (s_valid && !acc) return;
      if ($urandom_range(0, 3) != 0) begin
         if (fq.size() == 0)
            for (int i = 0; i < int'($urandom_range(1, 12)); i++)
               fq.push_back(8'($urandom));
         s_valid = 1'b1;
         s_data  = fq[0];
         s_last  = (fq.size() == 1);
      end else s_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] fr[$];
      logic [8:0] ex[$];
      int na;

      // reset, enable, alignment burst
      go_down();
      step(); step();
      rst_n = 1'b1;
      link_en = 1'b1;
      step();
      chk("en_no_valid", 9'(sym_valid), 9'd0);
      step(); step(); step();
      chk("align_3", 9'(aligned), 9'd0);
      step();
      chk("align_4", 9'(aligned), 9'd1);
      chk("align_sym", {sym_is_k, sym_out}, 9'h1BC);
      repeat (4) step();

      // plain frame, preceded by a pending skip
      wait_skip();
      fr = '{8'h11, 8'h22, 8'h33};
      send(fr, -1, 7, na);
      chk("acc_cnt", 9'(na), 9'd3);
      ex = '{9'h11C, 9'h1FB, 9'h011, 9'h022, 9'h033, 9'h1FD, 9'h1BC};
      chk_log("frame1", ex);

      // frame with a two-cycle stall after 0x22
      wait_skip();
      send(fr, 2, 8, na);
      ex = '{9'h11C, 9'h1FB, 9'h011, 9'h022, 9'h1F7, 9'h1F7, 9'h033,
             9'h1FD};
      chk_log("frame_stall", ex);

      // 10-byte frame spanning a skip wrap
      wait_skip();
      fr.delete();
      ex = '{9'h11C, 9'h1FB};
      for (int i = 0; i < 10; i++) begin
         fr.push_back(8'(8'hA0 + i));
         ex.push_back({1'b0, 8'(8'hA0 + i)});
      end
      ex.push_back(9'h1FD);
      ex.push_back(9'h11C);
      send(fr, -1, 14, na);
      chk_log("frame_wrap", ex);

      // link drop mid-frame
      wait_skip();
      s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
      step(); step(); step();
      s_data = 8'h22;
      link_en = 1'b0;
      step();
      chk("abort_sym", {sym_is_k, sym_out}, 9'h1FE);
      chk("abort_err", 9'(frame_err), 9'd1);
      s_valid = 1'b0;
      step();
      chk("down_valid", 9'(sym_valid), 9'd0);
      chk("down_ready", 9'(s_ready), 9'd0);
      link_en = 1'b1;
      repeat (AC + 1) step();
      chk("realign", 9'(aligned), 9'd1);

      // reset mid-frame
      wait_skip();
      s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
      step(); step(); step();
      s_data = 8'h22;
      rst_n = 1'b0;
      step();
      chk("rst_valid", 9'(sym_valid), 9'd0);
      chk("rst_err", 9'(frame_err), 9'd0);
      rst_n = 1'b1;
      s_valid = 1'b0;
      repeat (AC + 3) step();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         if (link_en) link_en = ($urandom_range(0, 149) != 0);
         else link_en = ($urandom_range(0, 3) == 0);
         step();
         src_update();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
